// File: rtl/rx_frame_ctrl_if.sv
// Buffer-write port and consumer ready/ack handshake of the RX frame controller.
// The controller drives the master side; the frame-buffer consumer drives frame_ack.
interface rx_frame_ctrl_if #(
    parameter int BUF_AW = 8
);
    logic              wr_en;
    logic              wr_sel;
    logic [BUF_AW-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              rd_sel;
    logic              frame_rdy;
    logic [BUF_AW-1:0] frame_len;
    logic              frame_ack;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, rd_sel, frame_rdy, frame_len,
        input  frame_ack
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, rd_sel, frame_rdy, frame_len,
        output frame_ack
    );
endinterface

// File: rtl/rx_frame_ctrl.sv
// RX frame controller: parses src/dst/len/payload/crc frames, filters and length-checks them,
// writes bytes into a ping-pong buffer pair and hands CRC-good frames to the consumer.
module rx_frame_ctrl #(
    parameter int BUF_AW = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_clk,
    input  logic        rx_bus_idle,
    input  logic [15:0] rx_crc,
    output logic        force_wait_idle,
    input  logic [7:0]  filter_addr,
    input  logic        promisc,
    output logic        err_crc,
    output logic        err_lost,
    output logic        err_abort,
    rx_frame_ctrl_if.master bus
);
    localparam int CNT_W = BUF_AW + 1;
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'((1 << BUF_AW) - 5);

    typedef enum logic [1:0] {
        S_WAIT_IDLE = 2'd0,
        S_IDLE      = 2'd1,
        S_RECV      = 2'd2,
        S_DROP      = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_byte_cnt;
    logic [7:0]        r_len;
    logic              r_buf_sel;
    logic              r_wr_en;
    logic              r_wr_sel;
    logic [BUF_AW-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_rd_sel;
    logic              r_frame_rdy;
    logic [BUF_AW-1:0] r_frame_len;
    logic              r_fwi;
    logic              r_err_crc;
    logic              r_err_lost;
    logic              r_err_abort;

    logic              w_dst_rej;
    logic              w_len_bad;
    logic              w_final;
    logic              w_buf_free;
    logic              w_wr_en;
    logic              w_fwi;
    logic              w_err_crc;
    logic              w_err_lost;
    logic              w_err_abort;
    logic              w_handover;
    logic [BUF_AW-1:0] w_wr_addr;

    assign w_dst_rej  = (r_byte_cnt == CNT_W'(1)) && !promisc &&
                        (rx_data != filter_addr) && (rx_data != 8'hFF);
    assign w_len_bad  = (r_byte_cnt == CNT_W'(2)) && (CNT_W'(rx_data) > MAX_LEN);
    // len+4 is never below 4, so a stale len cannot fire during the header bytes
    assign w_final    = (r_byte_cnt == (CNT_W'(r_len) + CNT_W'(4)));
    assign w_buf_free = !r_frame_rdy || bus.frame_ack;
    assign w_wr_addr  = (r_state == S_IDLE) ? '0 : r_byte_cnt[BUF_AW-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_WAIT_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a byte strobe takes precedence over bus idle in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT_IDLE: begin
                if (rx_bus_idle) w_state_nxt = S_IDLE;
                else             w_state_nxt = S_WAIT_IDLE;
            end
            S_IDLE: begin
                if (rx_data_clk) w_state_nxt = S_RECV;
                else             w_state_nxt = S_IDLE;
            end
            S_RECV: begin
                if (rx_data_clk) begin
                    if (w_dst_rej || w_len_bad) w_state_nxt = S_DROP;
                    else if (w_final)           w_state_nxt = S_WAIT_IDLE;
                    else                        w_state_nxt = S_RECV;
                end else if (rx_bus_idle) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RECV;
                end
            end
            S_DROP: begin
                if (rx_bus_idle) w_state_nxt = S_IDLE;
                else             w_state_nxt = S_DROP;
            end
            default: w_state_nxt = S_WAIT_IDLE;
        endcase
    end

    // Output decode: write strobe, resync request, error classes and handover.
    always_comb begin
        w_wr_en     = 1'b0;
        w_fwi       = 1'b0;
        w_err_crc   = 1'b0;
        w_err_lost  = 1'b0;
        w_err_abort = 1'b0;
        w_handover  = 1'b0;
        case (r_state)
            S_IDLE: w_wr_en = rx_data_clk;
            S_RECV: begin
                if (rx_data_clk) begin
                    w_wr_en = 1'b1;
                    if (w_dst_rej) begin
                        w_fwi = 1'b1;
                    end else if (w_len_bad) begin
                        w_fwi       = 1'b1;
                        w_err_abort = 1'b1;
                    end else if (w_final) begin
                        if (rx_crc != 16'h0000) w_err_crc  = 1'b1;
                        else if (w_buf_free)    w_handover = 1'b1;
                        else                    w_err_lost = 1'b1;
                    end else begin
                        w_fwi = 1'b0;
                    end
                end else if (rx_bus_idle) begin
                    w_err_abort = 1'b1;
                end else begin
                    w_err_abort = 1'b0;
                end
            end
            default: w_wr_en = 1'b0;
        endcase
    end

    // Byte counter, cleared whenever IDLE is entered, and captured length field.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_byte_cnt <= '0;
            r_len      <= '0;
        end else begin
            if (w_state_nxt == S_IDLE && r_state != S_IDLE) r_byte_cnt <= '0;
            else if (rx_data_clk && r_state == S_IDLE)     r_byte_cnt <= CNT_W'(1);
            else if (rx_data_clk && r_state == S_RECV)     r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            else                                           r_byte_cnt <= r_byte_cnt;
            if (rx_data_clk && r_state == S_RECV && r_byte_cnt == CNT_W'(2)) r_len <= rx_data;
            else                                                              r_len <= r_len;
        end
    end

    // Registered outputs. wr_sel is registered alongside wr_en/wr_addr so the final CRC
    // byte still lands in the buffer being handed over, one cycle before wr_sel flips.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_buf_sel   <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_sel    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'h00;
            r_rd_sel    <= 1'b1;
            r_frame_rdy <= 1'b0;
            r_frame_len <= '0;
            r_fwi       <= 1'b0;
            r_err_crc   <= 1'b0;
            r_err_lost  <= 1'b0;
            r_err_abort <= 1'b0;
        end else begin
            r_wr_en     <= w_wr_en;
            r_wr_sel    <= r_buf_sel;
            r_fwi       <= w_fwi;
            r_err_crc   <= w_err_crc;
            r_err_lost  <= w_err_lost;
            r_err_abort <= w_err_abort;
            if (w_wr_en) begin
                r_wr_addr <= w_wr_addr;
                r_wr_data <= rx_data;
            end else begin
                r_wr_addr <= r_wr_addr;
                r_wr_data <= r_wr_data;
            end
            if (w_handover) begin
                r_frame_rdy <= 1'b1;
                r_rd_sel    <= r_buf_sel;
                r_buf_sel   <= ~r_buf_sel;
                r_frame_len <= BUF_AW'(r_len) + BUF_AW'(3);
            end else if (bus.frame_ack && r_frame_rdy) begin
                r_frame_rdy <= 1'b0;
            end else begin
                r_frame_rdy <= r_frame_rdy;
            end
        end
    end

    assign bus.wr_en        = r_wr_en;
    assign bus.wr_sel       = r_wr_sel;
    assign bus.wr_addr      = r_wr_addr;
    assign bus.wr_data      = r_wr_data;
    assign bus.rd_sel       = r_rd_sel;
    assign bus.frame_rdy    = r_frame_rdy;
    assign bus.frame_len    = r_frame_len;
    assign force_wait_idle  = r_fwi;
    assign err_crc          = r_err_crc;
    assign err_lost         = r_err_lost;
    assign err_abort        = r_err_abort;
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: frame-level reference model driven by directed and random frames,
// compared against every DUT output on every cycle.
module tb_rx_frame_ctrl;
    localparam int BUF_AW  = 8;
    localparam int MAX_LEN = 251;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_data_clk = 1'b0;
    logic        rx_bus_idle = 1'b0;
    logic [15:0] rx_crc = 16'h0000;
    logic        force_wait_idle;
    logic [7:0]  filter_addr = 8'h05;
    logic        promisc = 1'b0;
    logic        err_crc, err_lost, err_abort;

    rx_frame_ctrl_if #(.BUF_AW(BUF_AW)) bus ();

    rx_frame_ctrl #(.BUF_AW(BUF_AW)) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_data_clk(rx_data_clk),
        .rx_bus_idle(rx_bus_idle), .rx_crc(rx_crc), .force_wait_idle(force_wait_idle),
        .filter_addr(filter_addr), .promisc(promisc), .err_crc(err_crc),
        .err_lost(err_lost), .err_abort(err_abort), .bus(bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_crc = 0, cnt_lost = 0, cnt_abort = 0, cnt_fwi = 0, cnt_wr = 0;
    bit chk_en = 1'b0;

    // model state: buffer being filled, consumer buffer, ready flag, published length
    logic       m_wr, m_rd, m_rdy;
    logic [7:0] m_len;
    // expected outputs after the most recent edge
    logic       e_wr_en, e_wr_sel, e_fwi, e_crc, e_lost, e_abort, e_rd, e_rdy;
    logic [7:0] e_addr, e_data, e_len;
    logic [7:0] fb[$];
    logic [7:0] mem[2][256];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // one clock cycle: drive inputs, advance the model, then publish expectations after the edge
    task automatic step(input bit rst, input bit dclk, input logic [7:0] d, input bit idle,
                        input logic [15:0] crc, input bit ack, input bit wr, input logic [7:0] waddr,
                        input bit fwi, input bit abort, input bit fin, input logic [7:0] flen);
        logic n_wr_en, n_wr_sel, n_fwi, n_crc, n_lost, n_abort;
        bit   free, hand;
        reset_n = !rst; rx_data_clk = dclk; rx_data = d; rx_bus_idle = idle;
        rx_crc = crc; bus.frame_ack = ack;
        n_wr_en = 1'b0; n_fwi = 1'b0; n_crc = 1'b0; n_lost = 1'b0; n_abort = 1'b0;
        if (rst) begin
            m_wr = 1'b0; m_rd = 1'b1; m_rdy = 1'b0; m_len = 8'h00; n_wr_sel = 1'b0;
        end else begin
            n_wr_sel = m_wr; n_wr_en = wr; n_fwi = fwi; n_abort = abort;
            free = !m_rdy || ack;
            hand = fin && (crc == 16'h0000) && free;
            n_crc  = fin && (crc != 16'h0000);
            n_lost = fin && (crc == 16'h0000) && !free;
            if (hand) begin
                m_rdy = 1'b1; m_rd = m_wr; m_wr = !m_wr; m_len = flen + 8'd3;
            end else if (ack && m_rdy) begin
                m_rdy = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        e_wr_en = n_wr_en; e_wr_sel = n_wr_sel; e_addr = waddr; e_data = d;
        e_fwi = n_fwi; e_crc = n_crc; e_lost = n_lost; e_abort = n_abort;
        e_rd = m_rd; e_rdy = m_rdy; e_len = m_len;
        chk_en = 1'b1;
    endtask

    task automatic idle_step(input bit idle, input bit ack, input bit abort);
        step(1'b0, 1'b0, 8'h00, idle, 16'h0000, ack, 1'b0, 8'h00, 1'b0, abort, 1'b0, 8'h00);
    endtask

    task automatic go_idle();
        idle_step(1'b1, 1'b0, 1'b0);
        idle_step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic build(input logic [7:0] dst, input logic [7:0] len);
        fb.delete();
        fb.push_back(8'($urandom));
        fb.push_back(dst);
        fb.push_back(len);
        for (int i = 0; i < int'(len) + 2; i++) fb.push_back(8'($urandom));
    endtask

    // Sends fb (first trunc bytes only when trunc >= 0), then one bus-idle cycle.
    // ack_mode: 0 never, 1 on the final byte, 2 random.
    task automatic send_frame(input int trunc, input logic [15:0] crc_last, input int ack_mode,
                              input int max_gap);
        int n, sent;
        bit rej, big, fin, wr, fwi, ab, ackv;
        n    = fb.size();
        rej  = !promisc && fb[1] != filter_addr && fb[1] != 8'hFF;
        big  = !rej && int'(fb[2]) > MAX_LEN;
        sent = (trunc >= 0 && trunc < n) ? trunc : n;
        for (int k = 0; k < sent; k++) begin
            repeat ($urandom_range(max_gap, 0))
                idle_step(1'b0, (ack_mode == 2) && ($urandom_range(3, 0) == 0), 1'b0);
            fin  = (k == n - 1) && !rej && !big;
            wr   = !(rej && k >= 2) && !(big && k >= 3);
            fwi  = (rej && k == 1) || (big && k == 2);
            ackv = (ack_mode == 1) ? fin : ((ack_mode == 2) && ($urandom_range(3, 0) == 0));
            step(1'b0, 1'b1, fb[k], 1'b0, fin ? crc_last : 16'($urandom), ackv, wr, 8'(k),
                 fwi, big && k == 2, fin, fb[2]);
        end
        ab = (sent >= 1) && (sent < n) && !(rej && sent >= 2) && !(big && sent >= 3);
        idle_step(1'b1, (ack_mode == 2) && ($urandom_range(3, 0) == 0), ab);
        idle_step(1'b0, 1'b0, 1'b0);
    endtask

    // per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("wr_en", 32'(bus.wr_en), 32'(e_wr_en));
            chk("wr_sel", 32'(bus.wr_sel), 32'(e_wr_sel));
            if (e_wr_en === 1'b1) begin
                chk("wr_addr", 32'(bus.wr_addr), 32'(e_addr));
                chk("wr_data", 32'(bus.wr_data), 32'(e_data));
            end
            chk("force_wait_idle", 32'(force_wait_idle), 32'(e_fwi));
            chk("err_crc", 32'(err_crc), 32'(e_crc));
            chk("err_lost", 32'(err_lost), 32'(e_lost));
            chk("err_abort", 32'(err_abort), 32'(e_abort));
            chk("rd_sel", 32'(bus.rd_sel), 32'(e_rd));
            chk("frame_rdy", 32'(bus.frame_rdy), 32'(e_rdy));
            chk("frame_len", 32'(bus.frame_len), 32'(e_len));
            if (bus.wr_en === 1'b1) begin
                mem[bus.wr_sel][bus.wr_addr] = bus.wr_data;
                cnt_wr++;
            end
            if (err_crc === 1'b1)         cnt_crc++;
            if (err_lost === 1'b1)        cnt_lost++;
            if (err_abort === 1'b1)       cnt_abort++;
            if (force_wait_idle === 1'b1) cnt_fwi++;
        end
    end

    initial begin
        logic [7:0] good[7];
        int c0, c1, c2;
        logic rs;
        good = '{8'h01, 8'h05, 8'h02, 8'hAA, 8'hBB, 8'hC0, 8'hDE};
        bus.frame_ack = 1'b0;

        step(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("rst_rd_sel", 32'(bus.rd_sel), 32'd1);
        chk("rst_wr_sel", 32'(bus.wr_sel), 32'd0);
        chk("rst_frame_rdy", 32'(bus.frame_rdy), 32'd0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
        go_idle();

        // bad CRC on the last byte
        fb.delete();
        foreach (good[i]) fb.push_back(good[i]);
        c0 = cnt_crc;
        send_frame(-1, 16'h1234, 0, 0);
        chk("badcrc_pulses", 32'(cnt_crc - c0), 32'd1);
        chk("badcrc_rdy", 32'(bus.frame_rdy), 32'd0);
        chk("badcrc_wr_sel", 32'(bus.wr_sel), 32'd0);

        // good frame lands in buffer 0 and is handed over
        foreach (mem[0][i]) mem[0][i] = 8'h00;
        send_frame(-1, 16'h0000, 0, 0);
        chk("good_rdy", 32'(bus.frame_rdy), 32'd1);
        chk("good_rd_sel", 32'(bus.rd_sel), 32'd0);
        chk("good_len", 32'(bus.frame_len), 32'd5);
        chk("good_wr_sel", 32'(bus.wr_sel), 32'd1);
        for (int i = 0; i < 7; i++) chk("good_mem", 32'(mem[0][i]), 32'(good[i]));
        idle_step(1'b0, 1'b1, 1'b0);
        chk("ack_rdy", 32'(bus.frame_rdy), 32'd0);

        // filter reject: only bytes 0 and 1 written, one resync pulse
        build(8'h07, 8'd3);
        c0 = cnt_fwi; c1 = cnt_wr;
        send_frame(-1, 16'h0000, 0, 1);
        chk("reject_fwi", 32'(cnt_fwi - c0), 32'd1);
        chk("reject_writes", 32'(cnt_wr - c1), 32'd2);
        promisc = 1'b1;
        build(8'h07, 8'd3);
        send_frame(-1, 16'h0000, 0, 1);
        chk("promisc_rdy", 32'(bus.frame_rdy), 32'd1);
        idle_step(1'b0, 1'b1, 1'b0);
        promisc = 1'b0;
        build(8'hFF, 8'd1);
        send_frame(-1, 16'h0000, 0, 1);
        chk("bcast_rdy", 32'(bus.frame_rdy), 32'd1);

        // lost frame, then ack coinciding with the next handover
        rs = bus.rd_sel;
        build(8'h05, 8'd2);
        c0 = cnt_lost;
        send_frame(-1, 16'h0000, 0, 0);
        chk("lost_pulses", 32'(cnt_lost - c0), 32'd1);
        chk("lost_rd_sel", 32'(bus.rd_sel), 32'(rs));
        build(8'h05, 8'd2);
        send_frame(-1, 16'h0000, 1, 0);
        chk("ackhand_rdy", 32'(bus.frame_rdy), 32'd1);
        chk("ackhand_rd_sel", 32'(bus.rd_sel), 32'(!rs));
        idle_step(1'b0, 1'b1, 1'b0);

        // truncation, over-length and max-length boundary
        build(8'h05, 8'd2);
        c0 = cnt_abort;
        send_frame(4, 16'h0000, 0, 0);
        chk("trunc_abort", 32'(cnt_abort - c0), 32'd1);
        build(8'h05, 8'd0);
        send_frame(-1, 16'h0000, 0, 0);
        chk("after_trunc_len", 32'(bus.frame_len), 32'd3);
        idle_step(1'b0, 1'b1, 1'b0);
        build(8'h05, 8'hFC);
        c0 = cnt_abort; c1 = cnt_fwi; c2 = cnt_wr;
        send_frame(6, 16'h0000, 0, 0);
        chk("toolong_abort", 32'(cnt_abort - c0), 32'd1);
        chk("toolong_fwi", 32'(cnt_fwi - c1), 32'd1);
        chk("toolong_writes", 32'(cnt_wr - c2), 32'd3);
        build(8'h05, 8'(MAX_LEN));
        send_frame(-1, 16'h0000, 0, 0);
        chk("maxlen_len", 32'(bus.frame_len), 32'd254);

        // reset during byte 3 with a frame still pending
        build(8'h05, 8'd4);
        for (int k = 0; k < 3; k++)
            step(1'b0, 1'b1, fb[k], 1'b0, 16'h0000, 1'b0, 1'b1, 8'(k), 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, fb[3], 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("midrst_rdy", 32'(bus.frame_rdy), 32'd0);
        chk("midrst_rd_sel", 32'(bus.rd_sel), 32'd1);
        chk("midrst_len", 32'(bus.frame_len), 32'd0);
        go_idle();

        // randomized frames against the model
        for (int f = 0; f < 40; f++) begin
            logic [7:0]  dst, len;
            logic [15:0] cl;
            int sel, trunc;
            sel     = $urandom_range(9, 0);
            promisc = (sel == 0);
            dst     = (sel < 4) ? filter_addr : ((sel < 6) ? 8'hFF : 8'($urandom));
            len     = ($urandom_range(9, 0) == 0) ? 8'($urandom_range(255, 252))
                                                   : 8'($urandom_range(12, 0));
            build(dst, len);
            trunc = ($urandom_range(5, 0) == 0) ? $urandom_range(int'(len) + 4, 0) : -1;
            cl    = ($urandom_range(3, 0) == 0) ? 16'($urandom_range(65535, 1)) : 16'h0000;
            send_frame(trunc, cl, 2, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
